// File: rtl/cska_pkg.sv
// Shared types and helpers for the pipelined carry-skip adder.
package cska_pkg;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] sum;
    logic                 carry;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
  } stage_t;

  function automatic int stages(input int width, input int block, input int bps);
    return width / (block * bps);
  endfunction

endpackage

// File: rtl/cska_block.sv
// One BLOCK-bit carry-skip group: ripple sum plus a propagate-driven skip mux on the carry.
module cska_block import cska_pkg::*; #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             p
);

  logic [BLOCK:0] rc;

  always_comb begin
    rc    = '0;
    s     = '0;
    rc[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      s[i]    = a[i] ^ b[i] ^ rc[i];
      rc[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & rc[i]);
    end
    p  = &(a ^ b);
    // A fully propagating group passes its carry-in straight through.
    co = p ? ci : rc[BLOCK];
  end

endmodule

// File: rtl/cska_pipe_adder.sv
// Pipelined carry-skip adder with valid/ready handshake on both sides.
// Define CSKA_OVF_EN to add the registered signed-overflow output ovf.
module cska_pipe_adder import cska_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4,
  parameter int BPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSKA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = stages(WIDTH, BLOCK, BPS);
  localparam int SW     = BLOCK * BPS;

  stage_t stage_in [STAGES];
  stage_t stage_d  [STAGES];
  stage_t stage_q  [STAGES];

  logic [STAGES-1:0][SW-1:0] grp_s;
  logic [STAGES-1:0]         stg_co;
  logic                      en;

  // The whole pipe advances together; bubbles are kept, never squeezed out.
  assign en       = out_ready | ~stage_q[STAGES-1].valid;
  assign in_ready = en;

  always_comb begin
    stage_in[0]                = '0;
    stage_in[0].valid          = in_valid;
    stage_in[0].a[WIDTH-1:0]   = a;
    stage_in[0].b[WIDTH-1:0]   = b;
    stage_in[0].carry          = cin;
    for (int k = 1; k < STAGES; k++) begin
      stage_in[k] = stage_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [BPS-1:0] grp_p;

    for (genvar j = 0; j < BPS; j++) begin : g_grp
      logic ci;
      logic co;

      if (j == 0) begin : g_first
        assign ci = stage_in[k].carry;
      end else begin : g_next
        assign ci = g_grp[j-1].co;
      end

      cska_block #(.BLOCK(BLOCK)) u_block (
        .a  (stage_in[k].a[k*SW + j*BLOCK +: BLOCK]),
        .b  (stage_in[k].b[k*SW + j*BLOCK +: BLOCK]),
        .ci (ci),
        .s  (grp_s[k][j*BLOCK +: BLOCK]),
        .co (co),
        .p  (grp_p[j])
      );
    end

    // Second skip level: when every group in the stage propagates, bypass the stage.
    assign stg_co[k] = (&grp_p) ? stage_in[k].carry : g_grp[BPS-1].co;
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k]                   = stage_in[k];
      stage_d[k].sum[k*SW +: SW]   = grp_s[k];
      stage_d[k].carry             = stg_co[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign sum       = stage_q[STAGES-1].sum[WIDTH-1:0];
  assign cout      = stage_q[STAGES-1].carry;

`ifdef CSKA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  always_comb begin
    ovf_d = stage_in[STAGES-1].a[WIDTH-1] ^ stage_in[STAGES-1].b[WIDTH-1]
          ^ grp_s[STAGES-1][SW-1] ^ stg_co[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cska_pipe_adder.sv
// Randomized and directed bench for cska_pipe_adder against an a+b+cin scoreboard.
// Honours CSKA_OVF_EN to also check the ovf output.
module tb_cska_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
`ifdef CSKA_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  cska_pipe_adder #(.WIDTH(32), .BLOCK(4), .BPS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSKA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  int checks = 0;
  int errors = 0;
  int in_count = 0;
  int out_count = 0;

  logic        obs_valid;
  logic        obs_in_ready;
  logic [31:0] obs_sum;
  logic        obs_cout;
  logic        obs_ovf;

  // Expected results in acceptance order: {ovf, cout, sum}
  logic [33:0] sb[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic mc);
    logic [32:0] full;
    longint      sres;
    logic        v;
    full = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
    sres = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
    v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return {v, full};
  endfunction

  // One clock cycle: drive inputs after the falling edge, sample, score, and record acceptance.
  task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                               input logic ic, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    #1;
    obs_valid    = out_valid;
    obs_in_ready = in_ready;
    obs_sum      = sum;
    obs_cout     = cout;
`ifdef CSKA_OVF_EN
    obs_ovf      = ovf;
`else
    obs_ovf      = 1'b0;
`endif
    if (obs_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 64'(obs_valid), 64'd0);
      end else begin
        checkOutput("sum", 64'(obs_sum), 64'(sb[0][31:0]));
        checkOutput("cout", 64'(obs_cout), 64'(sb[0][32]));
`ifdef CSKA_OVF_EN
        checkOutput("ovf", 64'(obs_ovf), 64'(sb[0][33]));
`endif
        if (ordy) begin
          void'(sb.pop_front());
          out_count++;
        end
      end
    end
    if (iv && obs_in_ready) begin
      sb.push_back(model(ia, ib, ic));
      in_count++;
    end
  endtask

  task automatic runOne(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                        input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    applyStimulus(1'b1, ia, ib, ic, 1'b1);
    checkOutput("one_accept", 64'(obs_in_ready), 64'd1);
    lat = 0;
    do begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      lat++;
    end while (!obs_valid && lat < 20);
    checkOutput("latency", 64'(lat), 64'd4);
    checkOutput("dir_sum", 64'(obs_sum), 64'(es));
    checkOutput("dir_cout", 64'(obs_cout), 64'(ec));
`ifdef CSKA_OVF_EN
    checkOutput("dir_ovf", 64'(obs_ovf), 64'(eo));
`else
    if (eo) $display("[TB] note: ovf expectation skipped, feature not built");
`endif
  endtask

  task automatic drainAll(input string tag);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      n++;
    end
    repeat (5) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    checkOutput(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_out;
    int base_in;
    int cyc;
    logic        iv;
    logic        ordy;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_sum", 64'(sum), 64'd0);
    checkOutput("rst_cout", 64'(cout), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef CSKA_OVF_EN
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
`endif

    runOne(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    runOne(32'h0000_000F, 32'h0000_0001, 1'b1, 32'h0000_0011, 1'b0, 1'b0);
    runOne(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    runOne(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    runOne(32'h1234_5678, 32'hEDCB_A987, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // Back-to-back: eight results on eight consecutive cycles
    base_out = out_count;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(i < 8, 32'(i), 32'hFFFF_FFF0 + 32'(i), 1'b0, 1'b1);
      if (i < 8) checkOutput("b2b_in_ready", 64'(obs_in_ready), 64'd1);
      if (i >= 4) checkOutput("b2b_valid", 64'(obs_valid), 64'd1);
    end
    checkOutput("b2b_count", 64'(out_count - base_out), 64'd8);
    drainAll("b2b_drained");

    // Fill the pipe, stall the output for three cycles, then drain
    base_out = out_count;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA000_0000 + 32'(i), 32'h6000_0000 - 32'(i), 1'(i & 1), 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0);
      checkOutput("stall_in_ready", 64'(obs_in_ready), 64'd0);
      checkOutput("stall_valid", 64'(obs_valid), 64'd1);
    end
    drainAll("stall_drained");
    checkOutput("stall_count", 64'(out_count - base_out), 64'd4);

    // Reset with operations in flight discards them all
    base_out = out_count;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h0F0F_0F0F, 32'(i), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_sum", 64'(sum), 64'd0);
    checkOutput("mid_rst_cout", 64'(cout), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("rst_discard", 64'(out_count - base_out), 64'd0);

    // Random traffic with random backpressure
    base_in = in_count;
    cyc = 0;
    while ((in_count - base_in) < 10000 && cyc < 60000) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      ra   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = ~ra;
        1:       begin ra = 32'hFFFF_FFFF; rb = 32'($urandom_range(0, 3)); end
        2:       begin ra = {ra[31], 31'h7FFF_FFFF}; rb = $urandom; end
        default: rb = $urandom;
      endcase
      applyStimulus(iv, ra, rb, rc, ordy);
      cyc++;
    end
    checkOutput("rand_accepts", 64'(in_count - base_in), 64'd10000);
    drainAll("rand_drained");
    checkOutput("total_balance", 64'(in_count - 3), 64'(out_count));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
